microplexer_cfg_ctrl: RTL and testbench

//  Serial configuration controller for a bank of NUM_MUX 4-input microplexers.

---
 rtl/microplexer_cfg_ctrl.sv | 147 ++++++++++++++
 tb/tb_microplexer_cfg_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/microplexer_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// microplexer_cfg_ctrl
//
// Serial configuration loader for a bank of NUM_MUX 4-input microplexers.
// A frame is opened with cfg_start. TOTAL = NUM_MUX*SEL_W bits are then
// shifted MSB first into a shadow register using a valid/ready handshake.
// Once the whole frame is in, it is committed in one step onto sel_bus, so
// the mux fabric never sees a partially loaded frame.
//
// Ports
//   clk        in   1         rising-edge clock
//   rst_n      in   1         synchronous reset, active-low
//   cfg_start  in   1         open a new frame (restarts a frame in progress)
//   cfg_bit    in   1         serial data bit
//   cfg_valid  in   1         cfg_bit is valid this cycle
//   cfg_ready  out  1         a bit is accepted this cycle (LOAD state)
//   cfg_busy   out  1         frame in progress (not IDLE)
//   cfg_done   out  1         one-cycle pulse: new masks are live on sel_bus
//   cfg_err    out  1         sticky: a bit was offered outside a frame
//   sel_bus    out  TOTAL     live masks, sel_bus[i*SEL_W +: SEL_W] = mux i
// -----------------------------------------------------------------------------
module microplexer_cfg_ctrl #(
    parameter int NUM_MUX = 8,
    parameter int SEL_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_start,
    input  logic                     cfg_bit,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    output logic                     cfg_busy,
    output logic                     cfg_done,
    output logic                     cfg_err,
    output logic [NUM_MUX*SEL_W-1:0] sel_bus
);

    localparam int TOTAL = NUM_MUX * SEL_W;
    localparam int CNT_W = $clog2(TOTAL);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [TOTAL-1:0]   shadow;
    logic [CNT_W-1:0]   bit_cnt;

    logic               load_clr;
    logic               shift_en;
    logic               commit_en;
    logic               err_set;
    logic               err_clr;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        next_state = state;
        load_clr   = 1'b0;
        shift_en   = 1'b0;
        commit_en  = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;

        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    next_state = S_LOAD;
                    load_clr   = 1'b1;
                    err_clr    = 1'b1;
                end else if (cfg_valid) begin
                    // Stray bit with no frame open: flag it and drop it.
                    err_set = 1'b1;
                end
            end

            S_LOAD: begin
                // A restart takes priority over a bit offered in the same cycle.
                if (cfg_start) begin
                    load_clr = 1'b1;
                end else if (cfg_valid) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_CNT) begin
                        next_state = S_COMMIT;
                    end
                end
            end

            S_COMMIT: begin
                commit_en  = 1'b1;
                next_state = S_IDLE;
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Handshake and status decoded from state only
    assign cfg_ready = (state == S_LOAD);
    assign cfg_busy  = (state != S_IDLE);

    // Shadow shift register, bit counter, live masks and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow   <= '0;
            bit_cnt  <= '0;
            sel_bus  <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            if (load_clr) begin
                shadow  <= '0;
                bit_cnt <= '0;
            end else if (shift_en) begin
                // MSB first: the first bit of the frame ends up in the top bit.
                shadow  <= {shadow[TOTAL-2:0], cfg_bit};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if (commit_en) begin
                sel_bus <= shadow;
            end
            cfg_done <= commit_en;

            if (err_clr) begin
                cfg_err <= 1'b0;
            end else if (err_set) begin
                cfg_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_microplexer_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_microplexer_cfg_ctrl
//
// Directed bench for microplexer_cfg_ctrl (NUM_MUX=8, SEL_W=4, 32-bit frame).
// A table of frames is loaded and checked in a loop, followed by hand-written
// sequences for restart, stray data and reset in the middle of a frame.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_microplexer_cfg_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cfg_start;
    logic        cfg_bit;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [31:0] sel_bus;

    int tests_run;
    int tests_failed;
    int done_cnt;

    microplexer_cfg_ctrl #(
        .NUM_MUX (8),
        .SEL_W   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_bit   (cfg_bit),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .sel_bus   (sel_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cfg_done pulses; sampled on the falling edge.
    always @(negedge clk) begin
        if (cfg_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [31:0] word;
        bit          stall;
        bit          b2b;     // start issued in the cycle cfg_done of the previous frame is high
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start_pulse();
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    // Sends w[n-1:0] MSB first; optional random stalls toggle cfg_bit while low.
    task automatic shift_bits(input logic [31:0] w, input int n, input bit stall);
        for (int i = n - 1; i >= 0; i--) begin
            if (stall) begin
                int s;
                s = 0;
                while (s < 3 && $urandom_range(0, 1) == 1) begin
                    cfg_valid = 1'b0;
                    cfg_bit   = ~cfg_bit;
                    chk("ready_in_stall", 32'(cfg_ready), 32'd1);
                    @(negedge clk);
                    s++;
                end
            end
            cfg_valid = 1'b1;
            cfg_bit   = w[i];
            @(negedge clk);
        end
        cfg_valid = 1'b0;
    endtask

    // Called on the falling edge just after the last bit was accepted.
    task automatic finish(input logic [31:0] prev, input logic [31:0] exp, input bit b2b_next);
        chk("commit_busy",  32'(cfg_busy),  32'd1);
        chk("commit_ready", 32'(cfg_ready), 32'd0);
        chk("commit_done",  32'(cfg_done),  32'd0);
        chk("commit_sel_old", sel_bus, prev);
        @(negedge clk);
        chk("done_pulse", 32'(cfg_done), 32'd1);
        chk("sel_new",    sel_bus,       exp);
        chk("idle_busy",  32'(cfg_busy), 32'd0);
        if (b2b_next) cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("done_one_cycle", 32'(cfg_done), 32'd0);
        if (b2b_next) chk("b2b_ready", 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] cur;
        int          d0;

        tests_run    = 0;
        tests_failed = 0;
        done_cnt     = 0;
        rst_n        = 1'b0;
        cfg_start    = 1'b0;
        cfg_bit      = 1'b0;
        cfg_valid    = 1'b0;

        vecs[0] = '{32'hA5A50F0F, 1'b0, 1'b0, 32'hA5A50F0F};
        vecs[1] = '{32'h80000001, 1'b0, 1'b0, 32'h80000001};
        vecs[2] = '{32'hA5A50F0F, 1'b1, 1'b0, 32'hA5A50F0F};
        vecs[3] = '{32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF};
        vecs[4] = '{32'h00000000, 1'b0, 1'b1, 32'h00000000};
        vecs[5] = '{32'hA5A50F0F, 1'b0, 1'b1, 32'hA5A50F0F};

        // Reset held for two edges
        @(negedge clk);
        @(negedge clk);
        chk("rst_sel",   sel_bus,         32'h0);
        chk("rst_ready", 32'(cfg_ready),  32'd0);
        chk("rst_busy",  32'(cfg_busy),   32'd0);
        chk("rst_done",  32'(cfg_done),   32'd0);
        chk("rst_err",   32'(cfg_err),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of frames
        cur = 32'h0;
        for (int i = 0; i < NVEC; i++) begin
            if (!vecs[i].b2b) start_pulse();
            chk("load_ready", 32'(cfg_ready), 32'd1);
            shift_bits(vecs[i].word, 32, vecs[i].stall);
            finish(cur, vecs[i].exp, (i + 1 < NVEC) && vecs[i + 1].b2b);
            cur = vecs[i].exp;
            if (i == 0) begin
                chk("mux0_sel", 32'(sel_bus[3:0]),   32'hF);
                chk("mux7_sel", 32'(sel_bus[31:28]), 32'hA);
            end
        end

        // Restart in the middle of a frame; the bit offered with the restart is dropped
        d0 = done_cnt;
        start_pulse();
        shift_bits(32'h000003FF, 10, 1'b0);
        chk("restart_sel_held", sel_bus, 32'hA5A50F0F);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        chk("restart_busy", 32'(cfg_busy), 32'd1);
        shift_bits(32'h12345678, 32, 1'b0);
        finish(32'hA5A50F0F, 32'h12345678, 1'b0);
        chk("restart_single_done", 32'(done_cnt - d0), 32'd1);

        // Stray data in IDLE
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("stray_err",  32'(cfg_err),  32'd1);
        chk("stray_sel",  sel_bus,       32'h12345678);
        chk("stray_busy", 32'(cfg_busy), 32'd0);
        @(negedge clk);
        chk("stray_err_sticky", 32'(cfg_err), 32'd1);
        start_pulse();
        chk("start_clears_err", 32'(cfg_err), 32'd0);
        shift_bits(32'h0F0F5A5A, 32, 1'b0);
        finish(32'h12345678, 32'h0F0F5A5A, 1'b0);

        // Reset after 20 bits of a frame
        d0 = done_cnt;
        start_pulse();
        shift_bits(32'h000ABCDE, 20, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_sel",   sel_bus,        32'h0);
        chk("midrst_busy",  32'(cfg_busy),  32'd0);
        chk("midrst_ready", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midrst_sel_hold", sel_bus, 32'h0);
        start_pulse();
        shift_bits(32'hFFFF0000, 32, 1'b0);
        finish(32'h0, 32'hFFFF0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
